// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone initiator: FSM states, default timeout
// and the harness slave register addresses.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [31:0] ADDR_ACTIVE = 32'h3000_0000;
  localparam logic [31:0] ADDR_WS2812 = 32'h3000_0100;
  localparam logic [31:0] ADDR_7SEG   = 32'h3000_0200;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator: one command in, one
// bus cycle, one response out, with a per-transaction timeout.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int SEL_W  = DATA_W / 8,
  localparam int TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshakes: a command transfers on a clock edge where cmd_valid and
  // cmd_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. rsp_valid/rsp_dat/rsp_err stay stable until then.

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_next;
  logic [TO_W-1:0] cnt;
  logic            accept, ack_take, to_take, rsp_take;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_take   = 1'b0;
    to_take    = 1'b0;
    rsp_take   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        // An ack in the last allowed cycle still counts as success.
        if (wbm_ack_i) begin
          ack_take   = 1'b1;
          state_next = RESP;
        end else if (cnt == TO_LAST) begin
          to_take    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        cnt       <= '0;
      end
      if (ack_take || to_take) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
        wbm_adr_o <= '0;
        rsp_valid <= 1'b1;
        rsp_err   <= to_take;
        rsp_dat   <= (ack_take && !wbm_we_o) ? wbm_dat_i : '0;
      end else if (state == BUS) begin
        // Bounded by TO_LAST above, so this never wraps.
        cnt <= cnt + TO_W'(1);
      end
      if (rsp_take) begin
        rsp_valid <= 1'b0;
        rsp_dat   <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
